// File: rtl/regfile_ctrl.sv
// Register-file controller: accepts 16-bit instructions, drives 8x8 register file read/write ports.
// Optional ALU status flags are enabled by defining REGFILE_CTRL_FLAGS_EN.
module regfile_ctrl (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_instr_valid,
   input  logic [15:0] i_instr,
   output logic        o_instr_ready,
   output logic [2:0]  o_sa,
   output logic [2:0]  o_sb,
   input  logic [7:0]  i_data_a,
   input  logic [7:0]  i_data_b,
   output logic [2:0]  o_dr,
   output logic        o_ld,
   output logic [7:0]  o_d_out,
   output logic        o_done,
   output logic        o_carry,
   output logic        o_zero
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_CLR} state_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_MOV = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_LDI = 3'd6;
   localparam logic [2:0] OP_CLR = 3'd7;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [7:0]  r_imm;
   logic [2:0]  r_cnt;
   logic        r_ready;
   logic [2:0]  r_sa;
   logic [2:0]  r_sb;
   logic [2:0]  r_dr;
   logic        r_ld;
   logic [7:0]  r_d_out;
   logic        r_done;
   logic [7:0]  w_result;

   always_comb begin
      w_result = 8'h00;
      case (r_op)
         OP_MOV:  w_result = i_data_a;
         OP_ADD:  w_result = i_data_a + i_data_b;
         OP_SUB:  w_result = i_data_a - i_data_b;
         OP_AND:  w_result = i_data_a & i_data_b;
         OP_OR:   w_result = i_data_a | i_data_b;
         OP_LDI:  w_result = r_imm;
         default: w_result = 8'h00;
      endcase
   end

`ifdef REGFILE_CTRL_FLAGS_EN
   logic r_carry;
   logic r_zero;
   logic w_carry;
   logic w_flag_op;

   // A modulo-256 sum smaller than an addend means the add wrapped.
   always_comb begin
      w_carry   = 1'b0;
      w_flag_op = 1'b0;
      case (r_op)
         OP_ADD:  begin w_carry = (w_result < i_data_a); w_flag_op = 1'b1; end
         OP_SUB:  begin w_carry = (i_data_a < i_data_b); w_flag_op = 1'b1; end
         OP_AND:  w_flag_op = 1'b1;
         OP_OR:   w_flag_op = 1'b1;
         default: w_flag_op = 1'b0;
      endcase
   end

   assign o_carry = r_carry;
   assign o_zero  = r_zero;
`else
   assign o_carry = 1'b0;
   assign o_zero  = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_op    <= OP_NOP;
         r_imm   <= 8'h00;
         r_cnt   <= 3'd0;
         r_ready <= 1'b0;
         r_sa    <= 3'd0;
         r_sb    <= 3'd0;
         r_dr    <= 3'd0;
         r_ld    <= 1'b0;
         r_d_out <= 8'h00;
         r_done  <= 1'b0;
`ifdef REGFILE_CTRL_FLAGS_EN
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ld   <= 1'b0;
               r_done <= 1'b0;
               if (r_ready && i_instr_valid) begin
                  r_ready <= 1'b0;
                  r_op    <= i_instr[15:13];
                  r_imm   <= i_instr[7:0];
                  r_sa    <= i_instr[9:7];
                  r_sb    <= i_instr[6:4];
                  // CLR writes its first register in the very next cycle.
                  if (i_instr[15:13] == OP_CLR) begin
                     r_state <= S_CLR;
                     r_cnt   <= 3'd0;
                     r_dr    <= 3'd0;
                     r_d_out <= 8'h00;
                     r_ld    <= 1'b1;
                  end else begin
                     r_state <= S_EXEC;
                     r_dr    <= i_instr[12:10];
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_EXEC: begin
               if (r_op != OP_NOP) r_d_out <= w_result;
               r_ld    <= (r_op != OP_NOP);
               r_done  <= 1'b1;
               r_state <= S_WB;
`ifdef REGFILE_CTRL_FLAGS_EN
               if (w_flag_op) begin
                  r_carry <= w_carry;
                  r_zero  <= (w_result == 8'h00);
               end
`endif
            end
            S_WB: begin
               r_ld    <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            S_CLR: begin
               if (r_cnt == 3'd7) begin
                  r_ld    <= 1'b0;
                  r_done  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt  <= r_cnt + 3'd1;
                  r_dr   <= r_cnt + 3'd1;
                  r_done <= (r_cnt == 3'd6);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_instr_ready = r_ready;
   assign o_sa          = r_sa;
   assign o_sb          = r_sb;
   assign o_dr          = r_dr;
   assign o_ld          = r_ld;
   assign o_d_out       = r_d_out;
   assign o_done        = r_done;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: directed cases plus randomized instruction traffic checked
// every cycle against a cycle-schedule model and a modelled register file.
module tb_regfile_ctrl;

   logic        clk;
   logic        rst_n;
   logic        i_instr_valid;
   logic [15:0] i_instr;
   logic        o_instr_ready;
   logic [2:0]  o_sa, o_sb, o_dr;
   logic [7:0]  i_data_a, i_data_b, o_d_out;
   logic        o_ld, o_done, o_carry, o_zero;

`ifdef REGFILE_CTRL_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   regfile_ctrl dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_instr_valid(i_instr_valid), .i_instr(i_instr),
      .o_instr_ready(o_instr_ready), .o_sa(o_sa), .o_sb(o_sb),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .o_dr(o_dr), .o_ld(o_ld),
      .o_d_out(o_d_out), .o_done(o_done), .o_carry(o_carry), .o_zero(o_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical register file driven by the DUT's write port.
   logic [7:0] p_rf [8];
   always @(posedge clk) if (o_ld) p_rf[o_dr] <= o_d_out;
   assign i_data_a = p_rf[o_sa];
   assign i_data_b = p_rf[o_sb];

   // Reference model: per-cycle expected output vector, built as a schedule at accept time.
   typedef struct packed {
      logic       ready;
      logic [2:0] sa, sb, dr;
      logic       ld;
      logic [7:0] dout;
      logic       done, carry, zero;
   } outv_t;

   outv_t      m_cur;
   outv_t      m_q[$];
   logic [7:0] m_rf [8];

   function automatic void alu(input logic [2:0] op, input int a, input int b, input int imm,
                               output int res, output bit cy, output bit z, output bit upd);
      res = 0; cy = 0; upd = 0;
      case (op)
         3'd1: res = a;
         3'd2: begin res = (a + b) % 256; cy = (a + b) > 255; upd = 1; end
         3'd3: begin res = (a - b + 256) % 256; cy = a < b; upd = 1; end
         3'd4: begin res = a & b; upd = 1; end
         3'd5: begin res = a | b; upd = 1; end
         3'd6: res = imm;
         default: res = 0;
      endcase
      z = (res == 0);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      outv_t e;
      logic [2:0] op;
      int res;
      bit cy, z, upd;
      if (!rst_n) begin
         m_cur = '0;
         m_q.delete();
      end else begin
         if (m_cur.ld) m_rf[m_cur.dr] = m_cur.dout;
         if (m_cur.ready && i_instr_valid) begin
            op = i_instr[15:13];
            e = m_cur;
            e.ready = 0; e.done = 0;
            e.sa = i_instr[9:7]; e.sb = i_instr[6:4];
            if (op == 3'd7) begin
               for (int k = 0; k < 8; k++) begin
                  e.ld = 1; e.dr = 3'(k); e.dout = 8'h00; e.done = (k == 7);
                  m_q.push_back(e);
               end
            end else begin
               e.ld = 0; e.dr = i_instr[12:10];
               m_q.push_back(e);
               alu(op, int'(m_rf[e.sa]), int'(m_rf[e.sb]), int'(i_instr[7:0]), res, cy, z, upd);
               e.ld = (op != 3'd0);
               e.done = 1;
               if (op != 3'd0) e.dout = 8'(res);
               if (FLAGS && upd) begin e.carry = cy; e.zero = z; end
               m_q.push_back(e);
            end
         end
         if (m_q.size() > 0) m_cur = m_q.pop_front();
         else begin m_cur.ready = 1; m_cur.ld = 0; m_cur.done = 0; end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("ready", o_instr_ready, m_cur.ready);
      chk("ld",    o_ld,          m_cur.ld);
      chk("done",  o_done,        m_cur.done);
      chk("dr",    o_dr,          m_cur.dr);
      chk("dout",  o_d_out,       m_cur.dout);
      chk("sa",    o_sa,          m_cur.sa);
      chk("sb",    o_sb,          m_cur.sb);
      chk("carry", o_carry,       m_cur.carry);
      chk("zero",  o_zero,        m_cur.zero);
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   // Presents an instruction, waits for acceptance; returns at the negedge of the first post-accept cycle.
   task automatic send(input logic [15:0] ins, input bit hold);
      int n;
      n = 0;
      i_instr_valid = 1'b1;
      i_instr = ins;
      while (!o_instr_ready && n < 50) begin tick(); n++; end
      if (n >= 50) begin
         chk("accept_timeout", 0, 1);
         i_instr_valid = 1'b0;
         return;
      end
      tick();
      if (hold) i_instr = 16'h4D2B;
      else i_instr_valid = 1'b0;
   endtask

   task automatic run(input logic [15:0] ins);
      send(ins, 1'b0);
      tick();
      tick();
   endtask

   initial begin : main
      logic [15:0] r;
      logic [2:0]  op;
      bit          acc_next;
      rst_n = 1'b1;
      i_instr_valid = 1'b0;
      i_instr = 16'h0000;
      #1 rst_n = 1'b0;
      tick();
      chk("lit_rst_ready", o_instr_ready, 0);
      chk("lit_rst_dout",  o_d_out, 0);
      tick();
      #1 rst_n = 1'b1;
      #1 chk("lit_ready_before_edge", o_instr_ready, 0);
      tick();
      chk("lit_ready_after_release", o_instr_ready, 1);

      $display("TXN CLR all");
      send(16'hE000, 1'b0);
      for (int k = 0; k < 8; k++) begin
         chk("lit_clr_dr", o_dr, k);
         chk("lit_clr_ld", o_ld, 1);
         chk("lit_clr_dout", o_d_out, 0);
         chk("lit_clr_done", o_done, (k == 7) ? 1 : 0);
         tick();
      end
      chk("lit_clr_ready_after", o_instr_ready, 1);

      $display("TXN LDI R3 0x5A");
      send(16'hCC5A, 1'b0);
      chk("lit_ldi_exec_ready", o_instr_ready, 0);
      chk("lit_ldi_exec_ld", o_ld, 0);
      tick();
      chk("lit_ldi_wb_ready", o_instr_ready, 0);
      chk("lit_ldi_wb_ld", o_ld, 1);
      chk("lit_ldi_wb_dr", o_dr, 3);
      chk("lit_ldi_wb_dout", o_d_out, 8'h5A);
      chk("lit_ldi_wb_done", o_done, 1);
      tick();
      chk("lit_ldi_idle_ready", o_instr_ready, 1);

      $display("TXN ADD R5 = R1(F0) + R2(20)");
      run({3'b110, 3'd1, 2'b00, 8'hF0});
      run({3'b110, 3'd2, 2'b00, 8'h20});
      send(16'h54A0, 1'b0);
      tick();
      chk("lit_add_dout", o_d_out, 8'h10);
      chk("lit_add_ld", o_ld, 1);
      chk("lit_add_dr", o_dr, 5);
      chk("lit_add_carry", o_carry, FLAGS ? 1 : 0);
      chk("lit_add_zero", o_zero, 0);
      tick();

      $display("TXN SUB R6 = R4(33) - R4(33)");
      run(16'hD033);
      send(16'h7A40, 1'b0);
      tick();
      chk("lit_sub_dout", o_d_out, 0);
      chk("lit_sub_ld", o_ld, 1);
      chk("lit_sub_carry", o_carry, 0);
      chk("lit_sub_zero", o_zero, FLAGS ? 1 : 0);
      tick();

      $display("TXN NOP with valid held and INSTR changing");
      send(16'h0800, 1'b1);
      chk("lit_nop_exec_ld", o_ld, 0);
      i_instr = 16'hC7FF;
      tick();
      chk("lit_nop_wb_done", o_done, 1);
      chk("lit_nop_wb_ld", o_ld, 0);
      i_instr_valid = 1'b0;
      tick();
      chk("lit_nop_idle_ready", o_instr_ready, 1);
      tick();
      chk("lit_nop_no_extra", o_ld, 0);

      $display("TXN CLR interrupted by reset at DR=3");
      send(16'hE000, 1'b0);
      tick(); tick(); tick();
      chk("lit_clrrst_dr", o_dr, 3);
      #1 rst_n = 1'b0;
      #1 chk("lit_clrrst_ld", o_ld, 0);
      chk("lit_clrrst_dr0", o_dr, 0);
      tick();
      #2 rst_n = 1'b1;
      #1 chk("lit_clrrst_ready_low", o_instr_ready, 0);
      tick();
      chk("lit_clrrst_ready_high", o_instr_ready, 1);

      $display("TXN random traffic");
      acc_next = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         if (!i_instr_valid || acc_next) begin
            r = 16'($urandom);
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 6));
            r[15:13] = op;
            i_instr = r;
            i_instr_valid = ($urandom_range(0, 3) != 0);
         end else if (!o_instr_ready && $urandom_range(0, 1) == 1) begin
            i_instr = 16'($urandom);
         end
         acc_next = o_instr_ready && i_instr_valid && rst_n;
         tick();
      end
      i_instr_valid = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      for (int k = 0; k < 8; k++) chk("regfile", p_rf[k], m_rf[k]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have no parameters; register count fixed at 8, data width 8.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 INSTR_VALID  input  1  requester has an instruction on INSTR.
REQ-005 INSTR  input  16  instruction: [15:13] opcode, [12:10] DR, [9:7] SA, [6:4] SB, [7:0] IMM (overlaps SA/SB).
REQ-006 INSTR_READY  output  1  controller accepts INSTR this cycle.
REQ-007 SA, SB  output  3 each  register file read selects.
REQ-008 DataA, DataB  input  8 each  register file read data, combinational from SA/SB.
REQ-009 DR  output  3  register file write select.
REQ-010 LD  output  1  register file write enable.
REQ-011 D_out  output  8  register file write data.
REQ-012 DONE  output  1  one-cycle pulse when an instruction retires.
REQ-013 CARRY, ZERO  output  1 each  ALU status flags.

Function
REQ-014 Opcodes SHALL be: 000 NOP, 001 MOV (DR<=A), 010 ADD (A+B), 011 SUB (A-B), 100 AND, 101 OR, 110 LDI (DR<=IMM), 111 CLR (write 0 to R0..R7).
REQ-015 FSM states SHALL be IDLE, EXEC, WB, CLR.
REQ-016 INSTR_READY SHALL be 1 only in IDLE; a transfer occurs when INSTR_VALID and INSTR_READY are both 1 at a rising edge.
REQ-017 On transfer, INSTR SHALL be captured; SA/SB/DR take the captured fields; next state EXEC, or CLR for opcode 111.
REQ-018 EXEC: compute result from DataA/DataB (or IMM for LDI); register result into D_out; next state WB.
REQ-019 ADD/SUB SHALL be 8-bit modulo; result bits beyond 8 discarded.
REQ-020 WB: LD=1 for opcodes 001-110, LD=0 for NOP; DONE=1; next state IDLE.
REQ-021 Accept-to-LD latency SHALL be 2 cycles; issue rate is one instruction per 3 cycles.
REQ-022 CLR: 8 consecutive cycles with LD=1, D_out=0, DR stepping 0..7 via internal 3-bit counter; DONE=1 on the DR=7 cycle; then IDLE.
REQ-023 LD SHALL be 0 in IDLE and EXEC; DONE SHALL be 0 except as in REQ-020/REQ-022.
REQ-024 SA, SB, DR, D_out SHALL hold their last values in IDLE.
REQ-025 INSTR_VALID while not in IDLE SHALL be ignored; the requester holds INSTR until accepted.
REQ-026 SA=SB, or DR equal to SA/SB, SHALL be legal; operands are read in EXEC before the WB write.

Reset
REQ-027 RESET_N low SHALL immediately force state IDLE, INSTR_READY=0, SA=SB=DR=0, LD=0, D_out=0, DONE=0, CARRY=0, ZERO=0, CLR counter 0.
REQ-028 INSTR_READY SHALL rise on the first rising edge after RESET_N deasserts.
REQ-029 Reset mid-instruction or mid-CLR SHALL abandon the operation with no further LD pulse.

Configuration
REQ-030 Macro REGFILE_CTRL_FLAGS_EN defined: in EXEC, CARRY<=carry-out (ADD) or borrow A<B (SUB), 0 for AND/OR; ZERO<=(result==0) for ADD/SUB/AND/OR; flags unchanged for NOP/MOV/LDI/CLR.
REQ-031 Macro undefined: CARRY and ZERO SHALL be constant 0 and no flag logic implemented.

Verification
REQ-032 LDI DR=3 IMM=0x5A -> INSTR_READY low 2 cycles, LD=1 with DR=3, D_out=0x5A two cycles after accept, DONE same cycle.
REQ-033 ADD SA=1 SB=2, DataA=0xF0, DataB=0x20 -> D_out=0x10, LD=1; with FLAGS_EN CARRY=1, ZERO=0.
REQ-034 SUB SA=4 SB=4 DataA=DataB=0x33 -> D_out=0x00; with FLAGS_EN CARRY=0, ZERO=1; without FLAGS_EN both 0.
REQ-035 CLR -> 8 cycles LD=1, DR=0..7, D_out=0, DONE only on DR=7, then INSTR_READY=1.
REQ-036 RESET_N pulsed low during CLR cycle DR=3 -> LD=0 immediately, no further writes, INSTR_READY=1 one edge after release.
REQ-037 INSTR_VALID held high through EXEC/WB with changing INSTR -> only the accepted instruction executes; NOP produces DONE with LD=0.
